xw_initiator: RTL and testbench

- RTL bus master for the xw single-cycle strobe bus (wr_s / rd_s / addr / data_wr / data_rd).
- Converts a valid/ready command stream into xw write and read strobes.
- Captures read data after a fixed responder latency and returns it on a valid/ready response stream.
- Sits in front of any xw responder (register file, memory model) and replaces the testbench driver in system-level builds.

---
 rtl/xw_pkg.sv | 14 +
 rtl/xw_rsp_fifo.sv | 62 ++++++
 rtl/xw_initiator.sv | 104 ++++++++++
 tb/tb_xw_initiator.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/xw_pkg.sv
// Shared definitions for the xw strobe-bus initiator and the benches that drive xw responders.
package xw_pkg;

    localparam int XW_AW     = 16;
    localparam int XW_DW     = 16;
    localparam int XW_RD_LAT = 1;

    typedef struct packed {
        logic              we;
        logic [XW_AW-1:0]  addr;
        logic [XW_DW-1:0]  wdata;
    } xw_cmd_t;

endpackage

// File: rtl/xw_rsp_fifo.sv
// Synchronous response FIFO for the xw initiator; a pop and a push may share a cycle even when full.
module xw_rsp_fifo
    import xw_pkg::*;
#(
    parameter int DW    = XW_DW,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_b,
    input  logic                         push,
    input  logic [DW-1:0]                push_data,
    input  logic                         pop,
    output logic [DW-1:0]                pop_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign do_pop   = pop & ~empty;
    // When full, the slot under wr_ptr is the one being popped this cycle, so overwriting it is safe.
    assign do_push  = push & (~full | do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/xw_initiator.sv
// xw bus master: turns a valid/ready command stream into registered strobes and returns read data in order.
module xw_initiator
    import xw_pkg::*;
#(
    parameter int AW        = XW_AW,
    parameter int DW        = XW_DW,
    parameter int RD_LAT    = XW_RD_LAT,
    parameter int RSP_DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst_b,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic           cmd_we,
    input  logic [AW-1:0]  cmd_addr,
    input  logic [DW-1:0]  cmd_wdata,
    output logic           wr_s,
    output logic           rd_s,
    output logic [AW-1:0]  addr,
    output logic [DW-1:0]  data_wr,
    input  logic [DW-1:0]  data_rd,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [DW-1:0]  rsp_data,
    output logic           busy
);

    localparam int CW = $clog2(RSP_DEPTH+1);
    localparam logic [CW-1:0] MAX_CREDIT = CW'(RSP_DEPTH);

    logic [CW-1:0]   credit;
    logic [RD_LAT:0] tok;
    logic            accept;
    logic            rd_accept;
    logic            rsp_pop;
    logic            fifo_push;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;

    // A credit is held from read accept until its response is popped, so the FIFO can never overflow.
    assign cmd_ready = rst_b & (credit < MAX_CREDIT);
    assign accept    = cmd_valid & cmd_ready;
    assign rd_accept = accept & ~cmd_we;
    assign rsp_pop   = rsp_valid & rsp_ready;
    assign fifo_push = tok[RD_LAT] & (~fifo_full | rsp_pop);
    assign rsp_valid = ~fifo_empty;
    assign busy      = (credit != '0) | wr_s | rd_s | (|tok) | (fifo_count != '0);

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            wr_s    <= 1'b0;
            rd_s    <= 1'b0;
            addr    <= '0;
            data_wr <= '0;
        end else begin
            wr_s <= accept & cmd_we;
            rd_s <= rd_accept;
            if (accept) begin
                addr <= cmd_addr;
            end
            if (accept && cmd_we) begin
                data_wr <= cmd_wdata;
            end
        end
    end

    // Token enters alongside rd_s and leaves RD_LAT cycles later, exactly when data_rd is valid.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            tok <= '0;
        end else begin
            tok <= {tok[RD_LAT-1:0], rd_accept};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            credit <= '0;
        end else begin
            case ({rd_accept, rsp_pop})
                2'b10:   credit <= credit + 1'b1;
                2'b01:   credit <= credit - 1'b1;
                default: credit <= credit;
            endcase
        end
    end

    xw_rsp_fifo #(
        .DW    (DW),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst_b     (rst_b),
        .push      (fifo_push),
        .push_data (data_rd),
        .pop       (rsp_pop),
        .pop_data  (rsp_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_xw_initiator.sv
// Scoreboard bench for xw_initiator: bus strobes and read responses are checked against queued expectations.
module tb_xw_initiator;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [15:0] cmd_addr;
    logic [15:0] cmd_wdata;
    logic        wr_s;
    logic        rd_s;
    logic [15:0] addr;
    logic [15:0] data_wr;
    logic [15:0] data_rd = 16'h0000;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        busy;

    typedef struct {
        logic        we;
        logic [15:0] a;
        logic [15:0] d;
        int          cyc;
    } bus_t;

    typedef struct {
        logic [15:0] d;
        int          cyc;
    } rsp_t;

    bus_t        bus_q[$];
    rsp_t        rsp_q[$];
    bus_t        mon_bus;
    rsp_t        mon_rsp;
    logic [15:0] last_wdata = 16'h0000;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    xw_initiator dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .wr_s      (wr_s),
        .rd_s      (rd_s),
        .addr      (addr),
        .data_wr   (data_wr),
        .data_rd   (data_rd),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] respVal(input logic [15:0] a);
        return (a == 16'h0020) ? 16'h1234 : ((a ^ 16'hA5A5) + 16'h0101);
    endfunction

    // Responder with one cycle of read latency.
    always @(posedge clk) begin
        if (rd_s) data_rd <= respVal(addr);
    end

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Monitor and scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        if (wr_s || rd_s) begin
            if (bus_q.size() == 0) begin
                checkOutput("strobeUnexpected", {30'd0, wr_s, rd_s}, 32'd0);
            end else begin
                mon_bus = bus_q.pop_front();
                checkOutput("strobeWr", wr_s, mon_bus.we);
                checkOutput("strobeRd", rd_s, !mon_bus.we);
                checkOutput("strobeCycle", cyc, mon_bus.cyc + 1);
                checkOutput("busAddr", addr, mon_bus.a);
                checkOutput("busData", data_wr, mon_bus.we ? mon_bus.d : last_wdata);
                if (mon_bus.we) last_wdata = mon_bus.d;
            end
        end
        if (rsp_valid) begin
            if (rsp_q.size() == 0) begin
                checkOutput("rspUnexpected", rsp_valid, 1'b0);
            end else begin
                mon_rsp = rsp_q[0];
                checkOutput("rspData", rsp_data, mon_rsp.d);
                checkOutput("rspLatency", (cyc >= mon_rsp.cyc + 3), 1'b1);
                if (rsp_ready) void'(rsp_q.pop_front());
            end
        end
        if (!rst_b) begin
            bus_q.delete();
            rsp_q.delete();
            last_wdata = 16'h0000;
        end else if (cmd_valid && cmd_ready) begin
            bus_q.push_back('{we: cmd_we, a: cmd_addr, d: cmd_wdata, cyc: cyc});
            if (!cmd_we) rsp_q.push_back('{d: respVal(cmd_addr), cyc: cyc});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command and return one step after the edge that accepted it; cmd_valid is left high.
    task automatic applyStimulus(input logic we, input logic [15:0] a, input logic [15:0] d);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = a;
        cmd_wdata = d;
        while (!cmd_ready && n < 50) begin
            tick();
            n++;
        end
        checkOutput("cmdReadyWait", cmd_ready, 1'b1);
        tick();
    endtask

    task automatic waitDrain();
        int n = 0;
        cmd_valid = 1'b0;
        while ((rsp_q.size() != 0 || bus_q.size() != 0 || busy) && n < 100) begin
            tick();
            n++;
        end
        checkOutput("drainRsp", rsp_q.size(), 0);
        checkOutput("drainBus", bus_q.size(), 0);
        checkOutput("drainBusy", busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_b     = 1'b0;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_addr  = 16'h0000;
        cmd_wdata = 16'h0000;
        rsp_ready = 1'b1;
        repeat (2) tick();
        checkOutput("rstCmdReady", cmd_ready, 1'b0);
        checkOutput("rstWr", wr_s, 1'b0);
        checkOutput("rstRd", rd_s, 1'b0);
        checkOutput("rstRspValid", rsp_valid, 1'b0);
        checkOutput("rstBusy", busy, 1'b0);
        checkOutput("rstAddr", addr, 16'h0000);
        checkOutput("rstDataWr", data_wr, 16'h0000);
        rst_b = 1'b1;
        tick();
        checkOutput("idleCmdReady", cmd_ready, 1'b1);

        $display("[TB] single write");
        applyStimulus(1'b1, 16'h0010, 16'hBEEF);
        cmd_valid = 1'b0;
        checkOutput("wrStrobe", wr_s, 1'b1);
        checkOutput("wrNoRd", rd_s, 1'b0);
        checkOutput("wrAddr", addr, 16'h0010);
        checkOutput("wrData", data_wr, 16'hBEEF);
        tick();
        checkOutput("wrOneCycle", wr_s, 1'b0);
        checkOutput("wrNoRsp", rsp_valid, 1'b0);
        checkOutput("wrDataHold", data_wr, 16'hBEEF);
        waitDrain();

        $display("[TB] single read");
        applyStimulus(1'b0, 16'h0020, 16'h5555);
        cmd_valid = 1'b0;
        checkOutput("rdStrobe", rd_s, 1'b1);
        checkOutput("rdDataWrHold", data_wr, 16'hBEEF);
        tick();
        checkOutput("rdNoRspYet", rsp_valid, 1'b0);
        checkOutput("rdBusy", busy, 1'b1);
        tick();
        checkOutput("rdRspValid", rsp_valid, 1'b1);
        checkOutput("rdRspData", rsp_data, 16'h1234);
        tick();
        checkOutput("rdRspPopped", rsp_valid, 1'b0);
        waitDrain();

        $display("[TB] back-to-back mixed");
        applyStimulus(1'b1, 16'h0001, 16'h1111);
        applyStimulus(1'b0, 16'h0002, 16'h0000);
        applyStimulus(1'b1, 16'h0003, 16'h3333);
        applyStimulus(1'b0, 16'h0004, 16'h0000);
        waitDrain();

        $display("[TB] credit stall");
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 16'h0040 + 16'(i), 16'h0000);
        checkOutput("stallFull", cmd_ready, 1'b0);
        cmd_we    = 1'b1;
        cmd_addr  = 16'h0099;
        cmd_wdata = 16'hCAFE;
        repeat (5) begin
            tick();
            checkOutput("stallReady", cmd_ready, 1'b0);
            checkOutput("stallNoWr", wr_s, 1'b0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checkOutput("stallReleased", cmd_ready, 1'b1);
        tick();
        cmd_valid = 1'b0;
        checkOutput("stallWrIssued", wr_s, 1'b1);
        rsp_ready = 1'b1;
        waitDrain();

        $display("[TB] full FIFO with concurrent push and pop");
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 16'h0070 + 16'(i), 16'h0000);
        cmd_valid = 1'b0;
        repeat (4) tick();
        checkOutput("fullNoCredit", cmd_ready, 1'b0);
        checkOutput("fullRspValid", rsp_valid, 1'b1);
        rsp_ready = 1'b1;
        applyStimulus(1'b0, 16'h0074, 16'h0000);
        waitDrain();

        $display("[TB] reset mid-operation");
        applyStimulus(1'b0, 16'h0050, 16'h0000);
        applyStimulus(1'b0, 16'h0051, 16'h0000);
        cmd_valid = 1'b0;
        rst_b = 1'b0;
        #1;
        checkOutput("midRstCmdReady", cmd_ready, 1'b0);
        tick();
        checkOutput("midRstWr", wr_s, 1'b0);
        checkOutput("midRstRd", rd_s, 1'b0);
        checkOutput("midRstRspValid", rsp_valid, 1'b0);
        checkOutput("midRstBusy", busy, 1'b0);
        checkOutput("midRstAddr", addr, 16'h0000);
        checkOutput("midRstDataWr", data_wr, 16'h0000);
        rst_b = 1'b1;
        repeat (4) begin
            tick();
            checkOutput("postRstNoRsp", rsp_valid, 1'b0);
        end
        applyStimulus(1'b0, 16'h0060, 16'h0000);
        waitDrain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
